// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, opcodes and mux codes for the multicycle MIPS control
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ADDI_WB   = 4'd9,
    S_BR_EXEC   = 4'd10,
    S_BR_TARGET = 4'd11,
    S_BR_TAKE   = 4'd12,
    S_JUMP      = 4'd13,
    S_ILLEGAL   = 4'd14,
    S_UNUSED    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_NONE = 2'b00;
  localparam logic [1:0] PCSRC_ULA  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// rtl/controle_multiciclo_if.sv - control unit <-> datapath signal bundle
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ula_zero;
  logic [3:0] inputULA;
  logic       pc_write;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, ula_zero,
    output inputULA, pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, illegal_op, state
  );

  modport slave (
    output opcode, funct, ula_zero,
    input  inputULA, pc_write, ior_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, illegal_op, state
  );
endinterface

// File: rtl/controle_ula.sv
// rtl/controle_ula.sv - combinational ULA-control decoder (alu_op/funct -> ULA code)
module controle_ula
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] inputULA,
  output logic       funct_valid
);

  logic [3:0] w_funct_code;

  // funct_valid does not depend on alu_op so DECODE can use it for dispatch
  always_comb begin
    funct_valid  = 1'b1;
    w_funct_code = ULA_ADD;
    case (funct)
      FN_ADD:  w_funct_code = ULA_ADD;
      FN_SUB:  w_funct_code = ULA_SUB;
      FN_AND:  w_funct_code = ULA_AND;
      FN_OR:   w_funct_code = ULA_OR;
      FN_SLT:  w_funct_code = ULA_SLT;
      default: funct_valid  = 1'b0;
    endcase
  end

  always_comb begin
    inputULA = ULA_ADD;
    case (alu_op)
      ALUOP_SUB:   inputULA = ULA_SUB;
      ALUOP_FUNCT: inputULA = w_funct_code;
      default:     inputULA = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle MIPS control unit (Moore FSM)
module controle_multiciclo
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  controle_multiciclo_if.master  bus
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec_state;
  logic       r_zero_q;

  logic [1:0] w_alu_op;
  logic       w_ula_en;
  logic [3:0] w_ula_code;
  logic       w_funct_valid;

  logic       w_pc_write;
  logic       w_ior_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic       w_illegal_op;

  controle_ula u_controle_ula (
    .alu_op      (w_alu_op),
    .funct       (bus.funct),
    .inputULA    (w_ula_code),
    .funct_valid (w_funct_valid)
  );

  // During reset the outputs show FETCH so the datapath sees a clean fetch setup
  assign w_dec_state = reset ? S_FETCH : r_state;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(bus.opcode))
          w_next = S_MEM_ADDR;
        else if (bus.opcode == OP_RTYPE)
          w_next = w_funct_valid ? S_R_EXEC : S_ILLEGAL;
        else if (bus.opcode == OP_ADDI)
          w_next = S_ADDI_EXEC;
        else if (bus.opcode == OP_BEQ)
          w_next = S_BR_EXEC;
        else if (bus.opcode == OP_J)
          w_next = S_JUMP;
        else
          w_next = S_ILLEGAL;
      end
      S_MEM_ADDR:  w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = S_MEM_WB;
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_BR_EXEC:   w_next = S_BR_TARGET;
      S_BR_TARGET: w_next = S_BR_TAKE;
      S_ILLEGAL:   w_next = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // zero_q keeps the A-B compare while the ULA is reused for the branch target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_zero_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_BR_TARGET)
        r_zero_q <= bus.ula_zero;
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ior_d      = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_REG;
    w_pc_source  = PCSRC_NONE;
    w_illegal_op = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_ula_en     = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ula_en    = 1'b1;
      end
      S_DECODE: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_ULA;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_ula_en    = 1'b1;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_REG;
        w_alu_op    = ALUOP_FUNCT;
        w_ula_en    = 1'b1;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_ADDI_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_ula_en    = 1'b1;
      end
      S_ADDI_WB:   w_reg_write = 1'b1;
      S_BR_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_REG;
        w_alu_op    = ALUOP_SUB;
        w_ula_en    = 1'b1;
      end
      S_BR_TARGET: begin
        w_alu_src_b = SRCB_IMM_SH2;
        w_ula_en    = 1'b1;
      end
      S_BR_TAKE: begin
        w_pc_write  = r_zero_q;
        w_pc_source = PCSRC_ULA;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL:   w_illegal_op = 1'b1;
      default:     ;
    endcase
  end

  assign bus.inputULA   = w_ula_en ? w_ula_code : 4'b0000;
  assign bus.pc_write   = w_pc_write  & ~reset;
  assign bus.ir_write   = w_ir_write  & ~reset;
  assign bus.reg_write  = w_reg_write & ~reset;
  assign bus.mem_write  = w_mem_write & ~reset;
  assign bus.ior_d      = w_ior_d;
  assign bus.mem_read   = w_mem_read;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.pc_source  = w_pc_source;
  assign bus.illegal_op = w_illegal_op;
  assign bus.state      = w_dec_state;

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle MIPS control unit: Moore FSM that sequences fetch/decode/execute/memory/writeback.
- Drives the 4-bit ULA operation code plus all datapath mux selects and write enables.
- The ULA registers its result on posedge clk, so every ULA result is consumed one state after it is requested.
- Includes a combinational ULA-control decoder (opcode/funct -> ULA code).

Parameters:
ILLEGAL_TRAP, 0, 1 = ILLEGAL state is sticky until reset; 0 = ILLEGAL lasts one cycle, then FETCH.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction bits 31..26 from instruction register
funct  input  6  instruction bits 5..0 from instruction register
ula_zero  input  1  1 when the registered ULA output equals 0
inputULA  output  4  ULA op: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
pc_write  output  1  PC load enable
ior_d  output  1  memory address select: 0 PC, 1 ULA result
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
reg_dst  output  1  write register: 0 rt, 1 rd
mem_to_reg  output  1  write data: 0 ULA result, 1 memory data
reg_write  output  1  register file write enable
alu_src_a  output  1  ULA A: 0 PC, 1 register A
alu_src_b  output  2  ULA B: 00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
pc_source  output  2  PC input: 01 ULA result, 10 jump target
illegal_op  output  1  high while in ILLEGAL
state  output  4  current state encoding, for debug

Behaviour:
- The clock is clk. Reset is synchronous and active-high on port reset.
- While reset is high:
  - state, and next state, = FETCH (0) and zero_q = 0.
  - pc_write, ir_write, reg_write and mem_write are forced to 0.
  - All other outputs show their FETCH values.
- All outputs are a pure decode of state. The only extra internal register is zero_q.
- Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH (0): mem_read, ir_write, ior_d=0, alu_src_a=0, alu_src_b=01, inputULA=0010 -> DECODE.
  - DECODE (1): pc_write, pc_source=01 (ULA now holds PC+4). Dispatch on opcode:
    - 100011 lw and 101011 sw -> MEM_ADDR
    - 000000 -> R_EXEC if funct is in {100000, 100010, 100100, 100101, 101010}, else ILLEGAL
    - 001000 addi -> ADDI_EXEC
    - 000100 beq -> BR_EXEC
    - 000010 j -> JUMP
    - any other opcode -> ILLEGAL
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, inputULA=0010 -> MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ (3): mem_read, ior_d=1 -> MEM_WB.
  - MEM_WB (4): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WRITE (5): mem_write, ior_d=1 -> FETCH.
  - R_EXEC (6): alu_src_a=1, alu_src_b=00, inputULA from funct (add 0010, sub 0110, and 0000, or 0001, slt 0111) -> R_WB.
  - R_WB (7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
  - ADDI_EXEC (8): alu_src_a=1, alu_src_b=10, inputULA=0010 -> ADDI_WB.
  - ADDI_WB (9): reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
  - BR_EXEC (10): alu_src_a=1, alu_src_b=00, inputULA=0110 -> BR_TARGET.
  - BR_TARGET (11): zero_q <= ula_zero (the A-B result). ULA computes PC+(imm<<2): alu_src_a=0, alu_src_b=11, inputULA=0010 -> BR_TAKE.
  - BR_TAKE (12): pc_write = zero_q, pc_source=01 -> FETCH.
  - JUMP (13): pc_write, pc_source=10 -> FETCH.
  - ILLEGAL (14): illegal_op=1, no write enables -> FETCH, or stay in ILLEGAL if ILLEGAL_TRAP=1.
- Encoding 15 is unreachable; if entered, next state = FETCH.
- Instruction latencies, counted from FETCH entry to the next FETCH:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq 5 cycles
  - j 3 cycles
  - illegal 3 cycles
- In DECODE, opcode and funct are sampled combinationally and must be stable (the IR was loaded at the end of FETCH).
- zero_q is written only in BR_TARGET and holds its value otherwise.
- Reset asserted mid-instruction aborts it at the next edge, with no write enable active during the reset cycles.

Decomposition:
- Package mips_pkg holds:
  - the state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - ULA codes: ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_SLT
  - mux select constants for alu_src_b and pc_source
- Sub-module controle_ula: combinational. Inputs are alu_op (2 bits: 00 add, 01 sub, 10 funct) and funct. Outputs are inputULA and funct_valid.

Test Plan:
- Reset held 3 cycles, then released with opcode=000000, funct=100000 -> state sequence 0,1,6,7,0; in state 6 inputULA=0010; reg_write=1 and reg_dst=1 only in state 7; all enables 0 during reset.
- lw (opcode=100011) -> states 0,1,2,3,4,0; ior_d=1 and mem_read=1 in state 3; mem_to_reg=1 and reg_write=1 in state 4. sw (101011) -> 0,1,2,5,0 with mem_write=1 only in state 5.
- beq with ula_zero=1 in BR_TARGET -> pc_write=1 in BR_TAKE. Repeat with ula_zero=0 -> pc_write=0 in BR_TAKE. Pulsing ula_zero in BR_TAKE itself has no effect.
- R-type funct sweep: 100010->0110, 100100->0000, 100101->0001, 101010->0111. funct=000111 -> ILLEGAL, illegal_op=1 for one cycle, then FETCH.
- ILLEGAL_TRAP=1 with opcode=111111 -> state stays 14 for 20 cycles; reset returns to 0. j (000010) -> 0,1,13,0 with pc_source=10 and pc_write=1 in state 13.
- Reset asserted during MEM_WRITE -> mem_write=0 that cycle; next state FETCH; zero_q cleared.
